// File: rtl/video_pixel_classifier_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_pixel_classifier_if : raw video in, classified video/stats out |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface video_pixel_classifier_if #(
  parameter int HIT_W = 20
);
  logic             HSyncIn;
  logic             VSyncIn;
  logic             VDEIn;
  logic [7:0]       Red;
  logic [7:0]       Green;
  logic [7:0]       Blue;
  logic [7:0]       Threshold;
  logic [7:0]       ChromaMax;
  logic             HSync;
  logic             VSync;
  logic             VDE;
  logic             Pixel;
  logic [10:0]      XPos;
  logic [9:0]       YPos;
  logic [HIT_W-1:0] FrameHits;
  logic             FrameValid;

  modport master (
    output HSyncIn, VSyncIn, VDEIn, Red, Green, Blue, Threshold, ChromaMax,
    input  HSync, VSync, VDE, Pixel, XPos, YPos, FrameHits, FrameValid
  );

  modport slave (
    input  HSyncIn, VSyncIn, VDEIn, Red, Green, Blue, Threshold, ChromaMax,
    output HSync, VSync, VDE, Pixel, XPos, YPos, FrameHits, FrameValid
  );
endinterface
`default_nettype wire

// File: rtl/video_pixel_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_pixel_classifier : RGB -> 1-bit "note bright" pixel, raster    |
// | coordinates and per-frame hit count. Revision 1.0                    |
// +----------------------------------------------------------------------+
module video_pixel_classifier #(
  parameter int LATENCY = 3,
  parameter int HIT_W   = 20
) (
  input  logic                     CLK,
  input  logic                     RST,
  video_pixel_classifier_if.slave  vid
);
  localparam logic [10:0]      X_MAX   = 11'd2047;
  localparam logic [9:0]       Y_MAX   = 10'd1023;
  localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

  logic [LATENCY-1:0] hs_sr_q, vs_sr_q, de_sr_q;
  logic [7:0]         red_q, green_q, blue_q;
  logic [15:0]        sum_q;
  logic [7:0]         chroma_q;
  logic               pixel_q;
  logic [7:0]         th_s_q, cm_s_q;
  logic [10:0]        xpos_q;
  logic [9:0]         ypos_q;
  logic [HIT_W-1:0]   cnt_q, frame_hits_q;
  logic               frame_valid_q, frame_armed_q;

  logic [7:0]         max_rg_d, min_rg_d, max_d, min_d;
  logic [15:0]        sum_d;
  logic               de_nxt_d, vde_rise_d, vde_fall_d, vs_rise_d, pixel_d;
  logic [10:0]        xpos_d;
  logic [9:0]         ypos_d;
  logic [HIT_W-1:0]   cnt_inc_d, cnt_d, frame_hits_d;
  logic               frame_valid_d;

  always_comb begin
    max_rg_d = (red_q > green_q) ? red_q : green_q;
    min_rg_d = (red_q < green_q) ? red_q : green_q;
    max_d    = (max_rg_d > blue_q) ? max_rg_d : blue_q;
    min_d    = (min_rg_d < blue_q) ? min_rg_d : blue_q;
    sum_d    = ({8'd0, red_q} * 16'd77) + ({8'd0, green_q} * 16'd150)
             + ({8'd0, blue_q} * 16'd29);

    // Edges are evaluated on the value about to appear at the outputs versus
    // what is there now, so every derived output lines up with VDE/VSync.
    de_nxt_d   = de_sr_q[LATENCY-2];
    vde_rise_d = de_nxt_d & ~de_sr_q[LATENCY-1];
    vde_fall_d = ~de_nxt_d & de_sr_q[LATENCY-1];
    vs_rise_d  = vs_sr_q[LATENCY-2] & ~vs_sr_q[LATENCY-1];

    // sum >= Th*256 is the same test as sum[15:8] >= Th.
    pixel_d = de_nxt_d & (sum_q >= {th_s_q, 8'd0}) & (chroma_q <= cm_s_q);

    xpos_d = xpos_q;
    if (de_nxt_d) begin
      if (vde_rise_d) begin
        xpos_d = 11'd0;
      end else if (xpos_q != X_MAX) begin
        xpos_d = xpos_q + 11'd1;
      end
    end

    ypos_d = ypos_q;
    if (vs_rise_d) begin
      ypos_d = 10'd0;
    end else if (vde_fall_d && (ypos_q != Y_MAX)) begin
      ypos_d = ypos_q + 10'd1;
    end

    cnt_inc_d     = (pixel_d && (cnt_q != HIT_MAX)) ? cnt_q + HIT_W'(1) : cnt_q;
    cnt_d         = cnt_inc_d;
    frame_hits_d  = frame_hits_q;
    frame_valid_d = 1'b0;
    if (vs_rise_d) begin
      cnt_d = '0;
      // The first VSync after reset closes a partial frame, so it is not reported.
      if (frame_armed_q) begin
        frame_hits_d  = cnt_inc_d;
        frame_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hs_sr_q       <= '0;
      vs_sr_q       <= '0;
      de_sr_q       <= '0;
      red_q         <= 8'd0;
      green_q       <= 8'd0;
      blue_q        <= 8'd0;
      sum_q         <= 16'd0;
      chroma_q      <= 8'd0;
      pixel_q       <= 1'b0;
      th_s_q        <= 8'd0;
      cm_s_q        <= 8'd0;
      xpos_q        <= 11'd0;
      ypos_q        <= 10'd0;
      cnt_q         <= '0;
      frame_hits_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_armed_q <= 1'b0;
    end else begin
      hs_sr_q       <= {hs_sr_q[LATENCY-2:0], vid.HSyncIn};
      vs_sr_q       <= {vs_sr_q[LATENCY-2:0], vid.VSyncIn};
      de_sr_q       <= {de_sr_q[LATENCY-2:0], vid.VDEIn};
      red_q         <= vid.Red;
      green_q       <= vid.Green;
      blue_q        <= vid.Blue;
      sum_q         <= sum_d;
      chroma_q      <= max_d - min_d;
      pixel_q       <= pixel_d;
      xpos_q        <= xpos_d;
      ypos_q        <= ypos_d;
      cnt_q         <= cnt_d;
      frame_hits_q  <= frame_hits_d;
      frame_valid_q <= frame_valid_d;
      if (vs_rise_d) begin
        th_s_q        <= vid.Threshold;
        cm_s_q        <= vid.ChromaMax;
        frame_armed_q <= 1'b1;
      end
    end
  end

  assign vid.HSync      = hs_sr_q[LATENCY-1];
  assign vid.VSync      = vs_sr_q[LATENCY-1];
  assign vid.VDE        = de_sr_q[LATENCY-1];
  assign vid.Pixel      = pixel_q;
  assign vid.XPos       = xpos_q;
  assign vid.YPos       = ypos_q;
  assign vid.FrameHits  = frame_hits_q;
  assign vid.FrameValid = frame_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_video_pixel_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_video_pixel_classifier : directed bench for the pixel classifier  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_video_pixel_classifier;
  localparam int HIT_W = 20;

  logic CLK = 1'b0;
  logic RST;

  video_pixel_classifier_if #(.HIT_W(HIT_W)) vif ();

  video_pixel_classifier #(.LATENCY(3), .HIT_W(HIT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .vid (vif)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       hs;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       pix;
  } vec_t;

  typedef struct {
    int   x;
    int   y;
    logic pix;
  } exp_t;

  int   n_pass  = 0;
  int   n_total = 0;
  int   y_exp   = 0;
  exp_t expq[$];

  task automatic chk(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    vif.Red   = r;
    vif.Green = g;
    vif.Blue  = b;
  endtask

  // Pops one expected active pixel each time the DUT presents VDE=1.
  task automatic check_out();
    exp_t e;
    if (vif.VDE === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_vde", 1, 0);
      end else begin
        e = expq.pop_front();
        chk($sformatf("xpos(y%0d,x%0d)", e.y, e.x), vif.XPos, e.x);
        chk($sformatf("ypos(y%0d,x%0d)", e.y, e.x), vif.YPos, e.y);
        chk($sformatf("pixel(y%0d,x%0d)", e.y, e.x), vif.Pixel, e.pix);
      end
    end else begin
      chk("pixel_gated", vif.Pixel, 0);
    end
  endtask

  // n active pixels: the first n_hit are white, the rest grey miss_val.
  task automatic drive_line(input int n, input int n_hit, input logic [7:0] miss_val,
                            input logic miss_pix);
    for (int i = 0; i < n; i++) begin
      vif.VDEIn = 1'b1;
      if (i < n_hit) begin
        set_rgb(8'd255, 8'd255, 8'd255);
        expq.push_back(exp_t'{i, y_exp, 1'b1});
      end else begin
        set_rgb(miss_val, miss_val, miss_val);
        expq.push_back(exp_t'{i, y_exp, miss_pix});
      end
      step();
      check_out();
    end
    vif.VDEIn = 1'b0;
    set_rgb(8'd255, 8'd255, 8'd255);
    for (int i = 0; i < 12; i++) begin
      vif.HSyncIn = (i >= 2 && i < 6);
      step();
      check_out();
    end
    vif.HSyncIn = 1'b0;
    y_exp++;
  endtask

  task automatic vsync_frame(input bit exp_valid, input int exp_hits);
    logic prev;
    bit   seen;
    prev = vif.VSync;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      vif.VSyncIn = (k < 2);
      step();
      check_out();
      if (vif.VSync === 1'b1 && prev === 1'b0) begin
        seen = 1'b1;
        chk("framevalid_at_rise", vif.FrameValid, exp_valid);
        if (exp_valid) chk("frame_hits", vif.FrameHits, exp_hits);
        chk("ypos_clear_at_rise", vif.YPos, 0);
      end
      prev = vif.VSync;
    end
    vif.VSyncIn = 1'b0;
    if (!seen) begin
      chk("vsync_timeout", 0, 1);
    end else begin
      step();
      chk("framevalid_one_cycle", vif.FrameValid, 0);
    end
    repeat (4) step();
    y_exp = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[10];
    int   tbl_hits;

    vt[0] = '{1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 1'b1};
    vt[1] = '{1'b1, 1'b1, 8'd200, 8'd200, 8'd200, 1'b1};  // luma exactly 200
    vt[2] = '{1'b0, 1'b1, 8'd199, 8'd199, 8'd199, 1'b0};
    vt[3] = '{1'b1, 1'b1, 8'd255, 8'd255, 8'd200, 1'b0};  // chroma 55
    vt[4] = '{1'b0, 1'b0, 8'd255, 8'd255, 8'd255, 1'b0};  // blanked white
    vt[5] = '{1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 1'b1};
    vt[6] = '{1'b0, 1'b1, 8'd0,   8'd0,   8'd0,   1'b0};
    vt[7] = '{1'b1, 1'b1, 8'd210, 8'd200, 8'd205, 1'b1};  // luma 203, chroma 10
    vt[8] = '{1'b0, 1'b1, 8'd200, 8'd216, 8'd200, 1'b1};  // chroma exactly 16
    vt[9] = '{1'b1, 1'b1, 8'd200, 8'd217, 8'd200, 1'b0};  // chroma 17

    RST           = 1'b1;
    vif.HSyncIn   = 1'b1;
    vif.VSyncIn   = 1'b1;
    vif.VDEIn     = 1'b1;
    vif.Threshold = 8'd0;
    vif.ChromaMax = 8'd0;
    set_rgb(8'd255, 8'd255, 8'd255);

    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("reset_outputs[%0d]", i),
          {vif.HSync, vif.VSync, vif.VDE, vif.Pixel, vif.XPos, vif.YPos,
           vif.FrameHits, vif.FrameValid}, 0);
    end

    RST         = 1'b0;
    vif.HSyncIn = 1'b0;
    vif.VSyncIn = 1'b0;
    step();
    chk("vde_latency_t1", vif.VDE, 0);
    step();
    chk("vde_latency_t2", vif.VDE, 0);
    step();
    chk("vde_latency_t3", vif.VDE, 1);
    chk("xpos_first_after_reset", vif.XPos, 0);
    vif.VDEIn = 1'b0;
    repeat (5) step();

    vif.Threshold = 8'd200;
    vif.ChromaMax = 8'd16;
    vsync_frame(1'b0, 0);

    tbl_hits = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        vif.HSyncIn = vt[i].hs;
        vif.VDEIn   = vt[i].de;
        set_rgb(vt[i].r, vt[i].g, vt[i].b);
      end else begin
        vif.HSyncIn = 1'b0;
        vif.VDEIn   = 1'b0;
      end
      step();
      if (i >= 2) begin
        chk($sformatf("tbl_pixel[%0d]", i - 2), vif.Pixel, vt[i-2].pix);
        chk($sformatf("tbl_vde[%0d]", i - 2), vif.VDE, vt[i-2].de);
        chk($sformatf("tbl_hsync[%0d]", i - 2), vif.HSync, vt[i-2].hs);
        if (vt[i-2].pix) tbl_hits++;
      end
    end
    repeat (4) step();
    vsync_frame(1'b1, tbl_hits);

    drive_line(640, 640, 8'd100, 1'b0);
    drive_line(640, 594, 8'd100, 1'b0);
    drive_line(640, 0,   8'd100, 1'b0);
    vsync_frame(1'b1, 1234);

    drive_line(100, 0, 8'd199, 1'b0);
    vsync_frame(1'b1, 0);

    drive_line(10, 0, 8'd150, 1'b0);
    vif.Threshold = 8'd100;
    drive_line(10, 0, 8'd150, 1'b0);
    vsync_frame(1'b1, 0);
    drive_line(10, 0, 8'd150, 1'b1);
    vsync_frame(1'b1, 10);

    chk("expected_queue_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
